// File: rtl/ps2_scan_decoder_if.sv
// Key-event bundle driven by the PS/2 receive stage toward the game FSM.
// The master modport belongs to the decoder and the slave modport to the consumer.
interface ps2_scan_decoder_if;
  logic       done;       // one-cycle pulse: key event valid
  logic [7:0] tasta;      // scan code of the last event
  logic       released;   // last event was F0-prefixed
  logic       extended;   // last event was E0-prefixed
  logic       frame_err;  // one-cycle pulse on an aborted or bad frame

  modport master (output done, tasta, released, extended, frame_err);
  modport slave  (input  done, tasta, released, extended, frame_err);
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receive stage.
// - Synchronizes the raw ps2_clock/ps2_data pins and deframes 11-bit frames.
// - Folds the E0 (extended) and F0 (break) prefixes into flags.
// - Emits one done pulse per key event, with the scan code on tasta.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
// Without it, the parity bit is clocked past and ignored.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,  // idle system clocks before a partial frame is dropped
  parameter int SYNC_STAGES    = 2       // synchronizer depth, minimum 2
) (
  input  logic                 clock,
  input  logic                 rst,        // asynchronous, active low
  input  logic                 ps2_clock,
  input  logic                 ps2_data,
  ps2_scan_decoder_if.master   evt
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fe;

  state_t                 state, state_n;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic [TO_W-1:0]        to_cnt;
  logic                   parity_ok, byte_valid, bad_frame, timeout;

  logic                   ext_pending, brk_pending;
  logic                   done_q, released_q, extended_q, frame_err_q;
  logic [7:0]             tasta_q;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;

  // Pin synchronizers and previous-clock register; presetting them to 1 keeps an idle bus from looking like an edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, making the shift chain order-independent.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;

  // Parity bit capture, only kept when it is checked.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)                        parity_bit <= 1'b0;
    else if (fe && state == S_PARITY) parity_bit <= data_s;
  end

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM next state, stop-bit verdict and timeout detection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a value held and infer a latch.
    state_n    = state;
    byte_valid = 1'b0;
    bad_frame  = 1'b0;
    // When an edge arrives in the cycle the count expires, the edge wins.
    timeout    = (state != S_IDLE) && !fe && (to_cnt == TO_LAST);
    if (fe) begin
      unique case (state)
        S_IDLE:   if (!data_s) state_n = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
        S_PARITY: state_n = S_STOP;
        S_STOP: begin
          state_n = S_IDLE;
          if (data_s && parity_ok) byte_valid = 1'b1;
          else                     bad_frame  = 1'b1;
        end
        default:  state_n = S_IDLE;
      endcase
    end
    if (timeout) state_n = S_IDLE;
  end

  // Frame FSM state, bit counter, LSB-first shift register and inactivity counter.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      to_cnt  <= '0;
    end else begin
      state <= state_n;
      if (fe) begin
        unique case (state)
          S_IDLE: bit_cnt <= 3'd0;
          S_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          default: ;
        endcase
      end
      if (fe || timeout || state == S_IDLE) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
    end
  end

  // Prefix folding and event registers; an error also drops pending prefixes.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      done_q      <= 1'b0;
      tasta_q     <= 8'h00;
      released_q  <= 1'b0;
      extended_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= bad_frame | timeout;
      if (bad_frame || timeout) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_valid) begin
        if (shift == 8'hE0) begin
          ext_pending <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_pending <= 1'b1;
        end else begin
          tasta_q     <= shift;
          released_q  <= brk_pending;
          extended_q  <= ext_pending;
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
          done_q      <= 1'b1;
        end
      end
    end
  end

  assign evt.done      = done_q;
  assign evt.tasta     = tasta_q;
  assign evt.released  = released_q;
  assign evt.extended  = extended_q;
  assign evt.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed frame table, hand-written corner
// sequences (latency, timeout, mid-frame reset) and random frames checked
// against a key-event model built from the protocol rules.
module tb_ps2_scan_decoder;

  localparam int TO   = 200;  // shortened timeout to keep runs short
  localparam int SYNC = 2;
  localparam int HALF = 20;   // system clocks per PS/2 clock half period
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic ps2_clock = 1'b1;
  logic ps2_data  = 1'b1;

  ps2_scan_decoder_if evt_if ();

  ps2_scan_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clock     (clock),
    .rst       (rst),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .evt       (evt_if.master)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Cycle count and pulse monitors, sampled on the falling edge.
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0;
  int fall_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (evt_if.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (evt_if.frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Key-event model: counts and held outputs derived from the protocol rules.
  int         m_done = 0, m_err = 0;
  logic [7:0] m_tasta = 8'h00;
  bit         m_rel = 0, m_extd = 0, m_ext_p = 0, m_brk_p = 0;

  task automatic model_reset();
    m_tasta = 8'h00; m_rel = 0; m_extd = 0; m_ext_p = 0; m_brk_p = 0;
  endtask

  task automatic model_err();
    m_err++; m_ext_p = 0; m_brk_p = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!stop_ok || (PAR_CHK && !par_ok)) model_err();
    else if (b == 8'hE0) m_ext_p = 1;
    else if (b == 8'hF0) m_brk_p = 1;
    else begin
      m_tasta = b; m_rel = m_brk_p; m_extd = m_ext_p;
      m_ext_p = 0; m_brk_p = 0; m_done++;
    end
  endtask

  // Drive the first nbits of an 11-bit frame, device style: data changes while the clock is high.
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clock); #1 ps2_data = f[i];
      repeat (HALF) @(posedge clock);
      #1 ps2_clock = 1'b0; fall_cyc = cyc;
      repeat (HALF) @(posedge clock);
      #1 ps2_clock = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    logic par;
    par = par_ok ? ~(^b) : ^b;
    return {stop_ok, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    send_bits(make_frame(b, par_ok, stop_ok), 11);
    #1 ps2_data = 1'b1;
    repeat (4 * HALF) @(posedge clock);
  endtask

  task automatic compare_model(input string tag, input int d0, input int e0);
    check({tag, " done"},     done_cnt - d0, m_done - d0);
    check({tag, " err"},      err_cnt - e0,  m_err - e0);
    check({tag, " tasta"},    evt_if.tasta,    m_tasta);
    check({tag, " released"}, evt_if.released, m_rel);
    check({tag, " extended"}, evt_if.extended, m_extd);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         par_ok;
    bit         stop_ok;
    logic [7:0] tasta;
    bit         rel;
    bit         ext;
    int         dd;
    int         de;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int d0, e0;

    // Directed frames; expectations follow the prefix/event rules by hand.
    vecs[0]  = '{8'h1D, 1, 1, 8'h1D, 0, 0, 1, 0};
    vecs[1]  = '{8'hF0, 1, 1, 8'h1D, 0, 0, 0, 0};
    vecs[2]  = '{8'h1D, 1, 1, 8'h1D, 1, 0, 1, 0};
    vecs[3]  = '{8'h1D, 1, 1, 8'h1D, 0, 0, 1, 0};
    vecs[4]  = '{8'hE0, 1, 1, 8'h1D, 0, 0, 0, 0};
    vecs[5]  = '{8'hF0, 1, 1, 8'h1D, 0, 0, 0, 0};
    vecs[6]  = '{8'h75, 1, 1, 8'h75, 1, 1, 1, 0};
    vecs[7]  = PAR_CHK ? '{8'h1B, 0, 1, 8'h75, 1, 1, 0, 1}
                       : '{8'h1B, 0, 1, 8'h1B, 0, 0, 1, 0};
    vecs[8]  = '{8'hF0, 1, 1, vecs[7].tasta, vecs[7].rel, vecs[7].ext, 0, 0};
    vecs[9]  = '{8'h5A, 1, 0, vecs[7].tasta, vecs[7].rel, vecs[7].ext, 0, 1};
    vecs[10] = '{8'h1C, 1, 1, 8'h1C, 0, 0, 1, 0};

    // Reset state.
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("reset outputs", {evt_if.done, evt_if.tasta, evt_if.released,
                            evt_if.extended, evt_if.frame_err}, 32'd0);
    #1 rst = 1'b1;
    repeat (5) @(posedge clock);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      d0 = done_cnt; e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].par_ok, vecs[i].stop_ok);
      model_frame(vecs[i].code, vecs[i].par_ok, vecs[i].stop_ok);
      check($sformatf("vec%0d done", i),     done_cnt - d0,    vecs[i].dd);
      check($sformatf("vec%0d err", i),      err_cnt - e0,     vecs[i].de);
      check($sformatf("vec%0d tasta", i),    evt_if.tasta,     vecs[i].tasta);
      check($sformatf("vec%0d released", i), evt_if.released,  vecs[i].rel);
      check($sformatf("vec%0d extended", i), evt_if.extended,  vecs[i].ext);
    end

    // Latency: done appears SYNC_STAGES+1 cycles after the stop-bit falling edge.
    send_frame(8'h2A, 1, 1);
    model_frame(8'h2A, 1, 1);
    check("latency", done_cyc - fall_cyc, SYNC + 1);

    // Timeout: E0, then a partial frame, then the PS/2 clock idles high.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hE0, 1, 1);
    model_frame(8'hE0, 1, 1);
    send_bits(make_frame(8'h1C, 1, 1), 5);
    for (int i = 0; i < TO + 4 * HALF && err_cnt == e0; i++) @(posedge clock);
    model_err();
    check("timeout err", err_cnt - e0, 1);
    repeat (3 * TO) @(posedge clock);
    check("timeout single", err_cnt - e0, 1);
    check("timeout no done", done_cnt - d0, 0);
    #1 ps2_data = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1, 1);
    model_frame(8'h1C, 1, 1);
    compare_model("after timeout", d0, e0);

    // Reset in mid-frame discards the partial frame silently.
    send_bits(make_frame(8'h23, 1, 1), 6);
    d0 = done_cnt; e0 = err_cnt;
    #1 rst = 1'b0; ps2_data = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("midreset outputs", {evt_if.tasta, evt_if.released, evt_if.extended}, 32'd0);
    check("midreset pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    model_reset();
    #1 rst = 1'b1;
    repeat (5) @(posedge clock);
    send_frame(8'h23, 1, 1);
    model_frame(8'h23, 1, 1);
    compare_model("after reset", d0, e0);

    // Random frames against the model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit         p, s;
      int         sel;
      sel = int'($urandom_range(0, 5));
      b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      p   = ($urandom_range(0, 5) != 0);
      s   = ($urandom_range(0, 7) != 0);
      d0 = done_cnt; e0 = err_cnt;
      send_frame(b, p, s);
      model_frame(b, p, s);
      compare_model($sformatf("rand%0d", i), d0, e0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- PS/2 keyboard receive stage; sits directly upstream of the game FSM.
- Synchronizes the raw ps2_clock/ps2_data pins and deframes 11-bit PS/2 frames.
- Folds the E0 (extended) and F0 (break) prefixes into flags.
- Emits one done pulse per complete key event, with the 8-bit scan code on tasta.

Parameters:
- TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clock  in  1  system clock, same domain as the game FSM.
- rst  in  1  asynchronous, active-low reset.
- ps2_clock  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- done  out  1  one-cycle pulse: key event valid.
- tasta  out  8  scan code of the last event; held until the next event.
- released  out  1  last event was a break (F0-prefixed); held with tasta.
- extended  out  1  last event was E0-prefixed; held with tasta.
- frame_err  out  1  one-cycle pulse on an aborted or bad frame.

Behaviour:
- Reset:
  - All outputs 0.
  - Synchronizers preset to 1 (bus idle).
  - Frame FSM in IDLE; bit counter 0; prefix flags cleared.
  - Reset asserted mid-frame discards the partial frame; no done or frame_err is produced.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops; one further register holds the previous synced clock.
  - Falling edge (fe) = prev=1 and synced=0, valid for exactly one cycle.
  - Data is sampled from the synced ps2_data in the fe cycle.
- Frame FSM, advancing only on fe:
  - IDLE: data=0 → DATA, bit count 0. data=1 → stay in IDLE, no error (spurious edge).
  - DATA: shift the sample in LSB-first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: data=1 and odd parity over data+parity OK → byte_valid for one cycle. Anything else → frame_err. Both cases → IDLE.
- Timeout:
  - A counter runs in any state other than IDLE and clears on every fe.
  - On reaching TIMEOUT_CYCLES: frame_err pulses, FSM → IDLE, prefix flags cleared.
- Prefix and event decoder, acting on byte_valid:
  - Byte 0xE0: set ext_pending; no done.
  - Byte 0xF0: set brk_pending; no done.
  - Any other byte: tasta ← byte, released ← brk_pending, extended ← ext_pending; both pending flags cleared; done pulses.
- Latency: done and the new tasta/released/extended are visible in the cycle after the fe that sampled the stop bit.
- frame_err also clears both pending flags, so no stale prefix attaches to the next code.
- Simultaneous events:
  - Timeout and fe in the same cycle: the fe wins and the counter clears.
  - Prefix bytes repeated (E0 E0, F0 F0) leave the flag set; no error.
- Minimum spacing between done pulses is one full frame (≥ 11 fe); downstream needs no backpressure.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the parity bit is checked; a mismatch aborts the frame with frame_err, as in Behaviour.
- Undefined: the parity bit is sampled and ignored; frame_err is raised only for a bad stop bit or a timeout.

Test Plan:
- Frame 0x1D (parity bit 1, stop 1) at 12.5 kHz PS/2 clock → one done pulse, tasta=0x1D, released=0, extended=0, frame_err=0.
- Frames F0 then 1D → only one done pulse (after 1D), tasta=0x1D, released=1, extended=0. A following 1D frame → done, released=0.
- Frames E0 F0 75 → one done pulse, tasta=0x75, extended=1, released=1.
- 0x1B sent with parity bit 0 (wrong) → frame_err pulse, no done, tasta keeps its previous value. Repeat with the macro undefined → done pulses with tasta=0x1B.
- E0 frame, then 5 bits of a frame, then PS/2 clock held high for TIMEOUT_CYCLES → frame_err pulses once. Then a clean 0x1C frame → done, tasta=0x1C, extended=0.
- rst pulled low after 6 bits of a frame, released, then a clean 0x23 frame → no done or frame_err during reset; then done with tasta=0x23.
